universal_shift_reg_n: RTL and testbench

Parametrised universal shift register: the next generation of the team's 4-bit shift register, generalised to WIDTH bits. It keeps the per-cycle shift, rotate, parallel-load and hold modes, and adds a burst serialiser. The burst loads D and shifts out LEN bits autonomously, with BUSY/DONE status. It sits between parallel datapath logic and serial links, and is driven by the same bench style as the 4-bit part.

---
 rtl/universal_shift_reg_n_if.sv | 28 ++
 rtl/universal_shift_reg_n.sv | 92 +++++++++
 tb/tb_universal_shift_reg_n.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/universal_shift_reg_n_if.sv
// Bus bundle for universal_shift_reg_n: mode/data controls in, register state and
// burst status out. The master drives the controls, the slave is the register.
interface universal_shift_reg_n_if #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH) + 1
);
   logic             ENB;
   logic             DIR;
   logic             S_IN;
   logic [1:0]       MODO;
   logic [WIDTH-1:0] D;
   logic             START;
   logic [CW-1:0]    LEN;
   logic [WIDTH-1:0] Q;
   logic             S_OUT;
   logic             BUSY;
   logic             DONE;

   modport master (
      output ENB, DIR, S_IN, MODO, D, START, LEN,
      input  Q, S_OUT, BUSY, DONE
   );

   modport slave (
      input  ENB, DIR, S_IN, MODO, D, START, LEN,
      output Q, S_OUT, BUSY, DONE
   );
endinterface

// File: rtl/universal_shift_reg_n.sv
// WIDTH-bit universal shift register (shift/rotate/load/hold) with an autonomous
// burst serialiser that loads D and shifts out up to WIDTH bits with BUSY/DONE status.
module universal_shift_reg_n #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH) + 1
) (
   input logic                  CLK,
   input logic                  RST,
   universal_shift_reg_n_if.slave bus
);

   typedef enum logic {IDLE, BURST} state_t;

   localparam logic [CW-1:0] WIDTH_CW = CW'(WIDTH);
   localparam logic [CW-1:0] ONE_CW   = CW'(1);

   state_t           state, state_n;
   logic [WIDTH-1:0] q, q_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             ldir, ldir_n;
   logic             done, done_n;
   logic             eff_dir;
   logic [CW-1:0]    len_sat;

   // dir=0 moves toward MSB (new bit enters at LSB), dir=1 moves toward LSB.
   function automatic logic [WIDTH-1:0] shift_q(input logic [WIDTH-1:0] v,
                                                input logic dir, input logic b);
      return dir ? {b, v[WIDTH-1:1]} : {v[WIDTH-2:0], b};
   endfunction

   assign eff_dir = (state == BURST) ? ldir : bus.DIR;
   assign len_sat = (bus.LEN > WIDTH_CW) ? WIDTH_CW : bus.LEN;

   always_comb begin
      state_n = state;
      q_n     = q;
      cnt_n   = cnt;
      ldir_n  = ldir;
      done_n  = 1'b0;
      if (bus.ENB) begin
         unique case (state)
            IDLE: begin
               if (bus.START) begin
                  q_n    = bus.D;
                  ldir_n = bus.DIR;
                  cnt_n  = len_sat;
                  if (len_sat != '0) state_n = BURST;
                  else               done_n  = 1'b1;
               end else begin
                  unique case (bus.MODO)
                     2'b00:   q_n = shift_q(q, bus.DIR, bus.S_IN);
                     2'b01:   q_n = shift_q(q, bus.DIR, bus.DIR ? q[0] : q[WIDTH-1]);
                     2'b10:   q_n = bus.D;
                     default: q_n = q;
                  endcase
               end
            end
            BURST: begin
               q_n   = shift_q(q, ldir, bus.S_IN);
               cnt_n = cnt - ONE_CW;
               if (cnt == ONE_CW) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         q     <= '0;
         cnt   <= '0;
         ldir  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         q     <= q_n;
         cnt   <= cnt_n;
         ldir  <= ldir_n;
         done  <= done_n;
      end
   end

   assign bus.Q     = q;
   assign bus.S_OUT = eff_dir ? q[0] : q[WIDTH-1];
   assign bus.BUSY  = (state == BURST);
   assign bus.DONE  = done;

endmodule

// File: tb/tb_universal_shift_reg_n.sv
// Directed bench for universal_shift_reg_n at WIDTH=8: modes, bursts, stalls,
// length saturation and asynchronous reset, against hand-computed values.
module tb_universal_shift_reg_n;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   universal_shift_reg_n_if #(.WIDTH(8)) bif();

   universal_shift_reg_n #(.WIDTH(8)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Launch a burst, then per busy cycle drive ENB from enb_mask (bit i = cycle i)
   // while toggling START/MODO/D as noise. Bits are collected only when the
   // upcoming edge actually shifts, so stalls do not duplicate them.
   task automatic burst(input logic [7:0] d, input logic [3:0] len, input logic dir,
                        input logic sin, input logic [15:0] enb_mask,
                        output logic [31:0] bits, output int nbits,
                        output int busy_cyc, output int done_cnt, output logic ended);
      int idle;
      int bi;
      bits = '0; nbits = 0; busy_cyc = 0; done_cnt = 0; idle = 0; bi = 0; ended = 1'b0;
      bif.D = d; bif.LEN = len; bif.DIR = dir; bif.S_IN = sin;
      bif.START = 1'b1; bif.ENB = 1'b1; bif.MODO = 2'b11;
      step();
      chk("burst_load_q", bif.Q, d);
      for (int i = 0; i < 40; i++) begin
         if (bif.DONE) done_cnt++;
         if (bif.BUSY) begin
            busy_cyc++;
            bif.ENB = enb_mask[bi];
            if (enb_mask[bi]) begin
               bits = {bits[30:0], bif.S_OUT};
               nbits++;
            end
            bi++;
            bif.START = 1'b1; bif.MODO = 2'b10; bif.D = 8'hFF; bif.DIR = ~dir;
         end else begin
            bif.START = 1'b0; bif.MODO = 2'b11; bif.ENB = 1'b1;
            idle++;
            if (idle == 3) begin
               ended = 1'b1;
               break;
            end
         end
         step();
      end
   endtask

   logic [31:0] bits;
   int          nbits, busy_cyc, done_cnt;
   logic        ended;

   initial begin
      rst = 1'b1;
      bif.ENB = 1'b0; bif.DIR = 1'b0; bif.S_IN = 1'b0; bif.MODO = 2'b11;
      bif.D = '0; bif.START = 1'b0; bif.LEN = '0;
      #12;
      chk("rst_q", bif.Q, 8'h00);
      chk("rst_busy", bif.BUSY, 1'b0);
      chk("rst_done", bif.DONE, 1'b0);
      rst = 1'b0;

      // asynchronous reset between edges
      bif.ENB = 1'b1; bif.MODO = 2'b10; bif.D = 8'hFF;
      step();
      chk("load_ff", bif.Q, 8'hFF);
      bif.MODO = 2'b11;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_q", bif.Q, 8'h00);
      chk("async_rst_busy", bif.BUSY, 1'b0);
      chk("async_rst_done", bif.DONE, 1'b0);
      chk("async_rst_sout", bif.S_OUT, 1'b0);
      rst = 1'b0;

      // load and rotate both ways
      bif.MODO = 2'b10; bif.D = 8'hA5;
      step();
      chk("load_a5", bif.Q, 8'hA5);
      bif.MODO = 2'b01; bif.DIR = 1'b0;
      step();
      chk("rot_left", bif.Q, 8'h4B);
      bif.DIR = 1'b1;
      step();
      chk("rot_right", bif.Q, 8'hA5);

      // shift in ones, then hold
      bif.MODO = 2'b10; bif.D = 8'h81;
      step();
      bif.MODO = 2'b00; bif.DIR = 1'b0; bif.S_IN = 1'b1;
      step(); step(); step();
      chk("shift_q", bif.Q, 8'h0F);
      chk("shift_sout_msb", bif.S_OUT, 1'b0);
      bif.DIR = 1'b1; #1;
      chk("idle_sout_lsb", bif.S_OUT, 1'b1);
      bif.MODO = 2'b11;
      for (int i = 0; i < 5; i++) step();
      chk("hold_q", bif.Q, 8'h0F);

      // plain 4-bit burst, MSB-first
      burst(8'hC3, 4'd4, 1'b0, 1'b0, 16'hFFFF, bits, nbits, busy_cyc, done_cnt, ended);
      chk("b4_ended", ended, 1'b1);
      chk("b4_bits", bits, 32'hC);
      chk("b4_nbits", nbits, 4);
      chk("b4_busy", busy_cyc, 4);
      chk("b4_done", done_cnt, 1);
      chk("b4_q", bif.Q, 8'h30);

      // same burst with two stalled cycles and noise on START/MODO/DIR
      burst(8'hC3, 4'd4, 1'b0, 1'b0, 16'h0033, bits, nbits, busy_cyc, done_cnt, ended);
      chk("stall_ended", ended, 1'b1);
      chk("stall_bits", bits, 32'hC);
      chk("stall_nbits", nbits, 4);
      chk("stall_busy", busy_cyc, 6);
      chk("stall_done", done_cnt, 1);
      chk("stall_q", bif.Q, 8'h30);

      // zero-length burst
      burst(8'h5A, 4'd0, 1'b0, 1'b0, 16'hFFFF, bits, nbits, busy_cyc, done_cnt, ended);
      chk("len0_ended", ended, 1'b1);
      chk("len0_busy", busy_cyc, 0);
      chk("len0_done", done_cnt, 1);
      chk("len0_q", bif.Q, 8'h5A);

      // oversize length saturates to WIDTH, LSB-first, fills with S_IN
      burst(8'h2D, 4'd15, 1'b1, 1'b1, 16'hFFFF, bits, nbits, busy_cyc, done_cnt, ended);
      chk("sat_ended", ended, 1'b1);
      chk("sat_bits", bits, 32'hB4);
      chk("sat_nbits", nbits, 8);
      chk("sat_busy", busy_cyc, 8);
      chk("sat_done", done_cnt, 1);
      chk("sat_q", bif.Q, 8'hFF);

      // reset mid-burst aborts with no DONE
      bif.D = 8'hFF; bif.LEN = 4'd8; bif.DIR = 1'b0; bif.S_IN = 1'b1;
      bif.START = 1'b1; bif.ENB = 1'b1; bif.MODO = 2'b11;
      step();
      bif.START = 1'b0;
      step(); step();
      chk("mid_busy", bif.BUSY, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_q", bif.Q, 8'h00);
      chk("mid_rst_busy", bif.BUSY, 1'b0);
      rst = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bif.DONE) done_cnt++;
      end
      chk("mid_rst_no_done", done_cnt, 0);
      chk("mid_rst_idle_q", bif.Q, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
